// File: rtl/step_sequencer.sv
// step_sequencer: tempo generator and chart sequencer that drives the scoring datapath
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_start, i_abort      start a song (IDLE/DONE), abort to IDLE (any state, wins over start)
//   o_chart_addr          chart ROM read address
//   i_chart_data          ROM data one cycle after the address: [4]=end, [3:0]=arrows
//   o_bpm_clk, o_beat_en  tempo square wave and one-cycle beat pulse
//   o_step                arrows expected this beat, held for the whole beat
//   o_playing, o_done     COUNTDOWN/PLAY indicator, DONE indicator
//   o_beat_count          chart beats issued in the current song, saturating
module step_sequencer #(
  parameter int DIV_HALF        = 25_000_000,
  parameter int COUNTDOWN_BEATS = 4,
  parameter int ADDR_W          = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_chart_addr,
  input  logic [4:0]        i_chart_data,
  output logic              o_bpm_clk,
  output logic              o_beat_en,
  output logic [3:0]        o_step,
  output logic              o_playing,
  output logic              o_done,
  output logic [ADDR_W:0]   o_beat_count
);
  localparam int HW = $clog2(DIV_HALF);
  localparam int CW = $clog2(COUNTDOWN_BEATS) + 1;
  localparam logic [ADDR_W:0] CHART_LEN = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [1:0] {IDLE, COUNTDOWN, PLAY, DONE} state_t;
  state_t          r_state;
  logic [HW-1:0]   r_half;
  logic [CW-1:0]   r_cd;
  logic [3:0]      r_next_step;
  logic            r_next_end;
  logic            w_active, w_wrap, w_rise, w_prefetch, w_end;
  assign w_active   = r_state == COUNTDOWN || r_state == PLAY;
  assign w_wrap     = r_half == HW'(DIV_HALF - 1);
  assign w_rise     = w_active && w_wrap && !o_bpm_clk;
  // first low cycle after a fall (or after start): address has been stable long enough
  assign w_prefetch = w_active && !o_bpm_clk && r_half == '0;
  // a full chart consumed without an end flag ends the song on the next beat
  assign w_end      = r_next_end || o_beat_count == CHART_LEN;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_half       <= '0;
      r_cd         <= '0;
      r_next_step  <= '0;
      r_next_end   <= 1'b0;
      o_chart_addr <= '0;
      o_bpm_clk    <= 1'b0;
      o_beat_en    <= 1'b0;
      o_step       <= '0;
      o_playing    <= 1'b0;
      o_done       <= 1'b0;
      o_beat_count <= '0;
    end else begin
      o_beat_en <= 1'b0;
      if (i_abort) begin
        r_state   <= IDLE;
        r_half    <= '0;
        o_bpm_clk <= 1'b0;
        o_step    <= '0;
        o_playing <= 1'b0;
        o_done    <= 1'b0;
      end else if (!w_active) begin
        if (i_start) begin
          r_state      <= COUNTDOWN;
          r_half       <= '0;
          r_cd         <= '0;
          o_chart_addr <= '0;
          o_beat_count <= '0;
          o_playing    <= 1'b1;
          o_done       <= 1'b0;
        end
      end else begin
        r_half <= w_wrap ? '0 : r_half + HW'(1);
        if (w_wrap)
          o_bpm_clk <= !o_bpm_clk;
        if (w_prefetch)
          {r_next_end, r_next_step} <= i_chart_data;
        if (w_rise) begin
          o_beat_en <= 1'b1;
          if (r_state == COUNTDOWN) begin
            r_cd   <= r_cd + CW'(1);
            o_step <= '0;
            if (r_cd == CW'(COUNTDOWN_BEATS - 1))
              r_state <= PLAY;
          end else if (w_end) begin
            // the end beat still pulses beatEn but the tempo wave stays low from here on
            r_state   <= DONE;
            o_step    <= '0;
            o_bpm_clk <= 1'b0;
            o_playing <= 1'b0;
            o_done    <= 1'b1;
          end else begin
            o_step       <= r_next_step;
            o_chart_addr <= o_chart_addr + ADDR_W'(o_chart_addr != '1);
            o_beat_count <= o_beat_count + (ADDR_W+1)'(o_beat_count != '1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: scoreboard bench for step_sequencer with a beat-level reference model
module tb_step_sequencer;
  localparam int DH = 4;
  localparam int CB = 2;
  localparam int AW = 2;
  localparam int BIG = 1 << 30;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] chart_addr;
  logic [4:0]    chart_data = '0;
  logic          bpm, beat_en, playing, done;
  logic [3:0]    step;
  logic [AW:0]   beat_count;
  logic [4:0]    rom [4];
  logic [3:0]    prev_step = '0;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  typedef struct {int at; int step; int playing; int done; int bc;} exp_t;
  exp_t          q[$];
  exp_t          m_e;

  step_sequencer #(.DIV_HALF(DH), .COUNTDOWN_BEATS(CB), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
    .o_chart_addr(chart_addr), .i_chart_data(chart_data), .o_bpm_clk(bpm),
    .o_beat_en(beat_en), .o_step(step), .o_playing(playing), .o_done(done),
    .o_beat_count(beat_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) chart_data <= rom[chart_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Song model: beat k rises DH*(2k-1) edges after the start edge; the first CB
  // beats are empty, then chart entries in order until an end flag or the chart runs out.
  function automatic int push_song(input int t0, input int stop);
    for (int k = 1; k <= CB + 5; k++) begin
      int at;
      int idx;
      at = t0 + DH * (2 * k - 1);
      idx = k - CB - 1;
      if (at >= stop) return -1;
      if (k <= CB) q.push_back('{at, 0, 1, 0, 0});
      else if (idx >= 4 || rom[idx][4]) begin
        q.push_back('{at, 0, 0, 1, idx});
        return at;
      end else q.push_back('{at, int'(rom[idx][3:0]), 1, 0, idx + 1});
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (beat_en) begin
        if (q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          m_e = q.pop_front();
          check("beat_time", cyc, m_e.at);
          check("beat_step", int'(step), m_e.step);
          check("beat_playing", int'(playing), m_e.playing);
          check("beat_done", int'(done), m_e.done);
          check("beat_count", int'(beat_count), m_e.bc);
          if (m_e.done == 0) check("beat_bpm_high", int'(bpm), 1);
        end
      end
      if (step != prev_step && !beat_en && step != 4'd0)
        check("step_stable", int'(step), int'(prev_step));
      prev_step = step;
    end
  end

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic start_song(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t2, e, e1, e2, b, hi, p;
    for (int i = 0; i < 4; i++) rom[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_step", int'(step), 0);
    check("rst_bpm", int'(bpm), 0);
    check("rst_beat_en", int'(beat_en), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_done", int'(done), 0);
    check("rst_beat_count", int'(beat_count), 0);
    check("rst_chart_addr", int'(chart_addr), 0);
    reset = 1'b0;

    rom = '{5'h01, 5'h06, 5'h00, 5'h1F};
    start_song(t0);
    e = push_song(t0, BIG);
    wait_until(e);
    check("a_done", int'(done), 1);
    check("a_playing", int'(playing), 0);
    check("a_beat_count", int'(beat_count), 3);
    check("a_step", int'(step), 0);
    hi = 0;
    repeat (20) begin @(negedge clk); hi |= int'(bpm); end
    check("a_bpm_after_done", hi, 0);
    check("a_drained", q.size(), 0);

    for (int i = 0; i < 4; i++) rom[i] = {1'b0, 4'($urandom_range(1, 15))};
    start_song(t0);
    b = t0 + DH * (2 * CB + 1);
    void'(push_song(t0, b + 2));
    wait_until(b + 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_step", int'(step), 0);
    check("ab_bpm", int'(bpm), 0);
    check("ab_playing", int'(playing), 0);
    check("ab_done", int'(done), 0);
    check("ab_beat_count", int'(beat_count), 1);
    repeat (100) @(negedge clk);
    check("ab_drained", q.size(), 0);
    start_song(t0);
    e = push_song(t0, BIG);
    wait_until(e + 2);
    check("replay_done", int'(done), 1);
    check("replay_full_chart", int'(beat_count), 4);
    check("replay_drained", q.size(), 0);

    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    start = 1'b1;
    hi = 0;
    repeat (3) begin @(negedge clk); hi |= int'(playing); end
    start = 1'b0;
    abort = 1'b0;
    repeat (40) begin @(negedge clk); hi |= int'(playing); end
    check("start_abort_idle", hi, 0);

    rom = '{5'h03, 5'h10, 5'h05, 5'h07};
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    e1 = push_song(t0, BIG);
    t2 = e1 + 1;
    e2 = push_song(t2, BIG);
    wait_until(e1);
    check("held_done", int'(done), 1);
    wait_until(e1 + 1);
    check("held_restart_playing", int'(playing), 1);
    check("held_restart_done", int'(done), 0);
    start = 1'b0;
    wait_until(e2 + 3);
    check("held_second_done", int'(done), 1);
    check("held_drained", q.size(), 0);

    for (int it = 0; it < 4; it++) begin
      p = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) rom[i] = {i == p, 4'($urandom_range(0, 15))};
      start_song(t0);
      e = push_song(t0, BIG);
      wait_until(e + 2);
      check("rand_done", int'(done), 1);
      check("rand_drained", q.size(), 0);
    end

    rom[0] = 5'h0F;
    for (int i = 1; i < 4; i++) rom[i] = {1'b0, 4'($urandom_range(0, 15))};
    start_song(t0);
    b = t0 + DH * (2 * CB + 1);
    void'(push_song(t0, b + 1));
    wait_until(b);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_step", int'(step), 0);
    check("async_bpm", int'(bpm), 0);
    check("async_playing", int'(playing), 0);
    check("async_beat_count", int'(beat_count), 0);
    check("async_chart_addr", int'(chart_addr), 0);
    check("async_drained", q.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    hi = 0;
    repeat (60) begin @(negedge clk); hi |= int'(playing); end
    check("async_stays_idle", hi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
